// File: rtl/alu_muldiv.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide,
// 32 iterations per operation, with single-cycle handling of divide special cases.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module alu_muldiv (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  md_start,
    input  logic [2:0]            md_op,
    input  logic [`CPU_WIDTH-1:0] md_src1,
    input  logic [`CPU_WIDTH-1:0] md_src2,
    input  logic                  md_flush,
    output logic                  md_busy,
    output logic                  md_valid,
    output logic [`CPU_WIDTH-1:0] md_result
);
    localparam int unsigned W = `CPU_WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t         state;
    logic [5:0]     cnt;
    logic [2:0]     op;
    logic           neg_hi;
    logic           neg_rem;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;

    logic           s1_signed, s2_signed, s1_neg, s2_neg;
    logic           div_zero, div_ovf;
    logic [W-1:0]   mag1, mag2, special_res;
    logic [W:0]     mul_sum, div_trial;
    logic [2*W-1:0] acc_next, prod;
    logic [W-1:0]   quo, rem, final_res;

    // Operand decode for the start cycle, using the live inputs.
    always_comb begin
        s1_signed   = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
        s2_signed   = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        s1_neg      = s1_signed & md_src1[W-1];
        s2_neg      = s2_signed & md_src2[W-1];
        mag1        = s1_neg ? -md_src1 : md_src1;
        mag2        = s2_neg ? -md_src2 : md_src2;
        div_zero    = md_op[2] && (md_src2 == '0);
        div_ovf     = md_op[2] && !md_op[0] && (md_src1 == {1'b1, {(W-1){1'b0}}})
                      && (md_src2 == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = md_op[1] ? md_src1 : '1;
        end else begin
            special_res = md_op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        end
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = acc[2*W-1:W-1] - {1'b0, opnd};
        if (op[2]) begin
            acc_next = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[W-1:1]};
        end
        prod = neg_hi ? -acc_next : acc_next;
        quo  = neg_hi ? -acc_next[W-1:0] : acc_next[W-1:0];
        rem  = neg_rem ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
        case (op)
            3'd0:                final_res = prod[W-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod[2*W-1:W];
            3'd4, 3'd5:          final_res = quo;
            default:             final_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            op        <= '0;
            neg_hi    <= 1'b0;
            neg_rem   <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            md_valid  <= 1'b0;
            md_result <= '0;
        end else if (md_flush) begin
            state    <= StIdle;
            cnt      <= '0;
            md_valid <= 1'b0;
        end else begin
            md_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (md_start) begin
                        op      <= md_op;
                        neg_hi  <= s1_neg ^ s2_neg;
                        neg_rem <= s1_neg;
                        cnt     <= '0;
                        if (div_zero || div_ovf) begin
                            state     <= StDone;
                            md_valid  <= 1'b1;
                            md_result <= special_res;
                        end else begin
                            state <= StCalc;
                            opnd  <= md_op[2] ? mag2 : mag1;
                            acc   <= {{W{1'b0}}, (md_op[2] ? mag1 : mag2)};
                        end
                    end
                end
                StCalc: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state     <= StDone;
                        cnt       <= '0;
                        md_valid  <= 1'b1;
                        md_result <= final_res;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign md_busy = (state != StIdle);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: expected results queued at start, popped at md_valid.
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_start = 1'b0;
    logic        md_flush = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md_src1 = 32'd0;
    logic [31:0] md_src2 = 32'd0;
    logic        md_busy;
    logic        md_valid;
    logic [31:0] md_result;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_src1   (md_src1),
        .md_src2   (md_src2),
        .md_flush  (md_flush),
        .md_busy   (md_busy),
        .md_valid  (md_valid),
        .md_result (md_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble inputs after acceptance, wait (bounded) for md_valid.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit hold);
        int cyc;
        int busy_cycles;
        logic [31:0] want;
        md_op = op;
        md_src1 = a;
        md_src2 = b;
        md_start = 1'b1;
        tick();
        exp_q.push_back(exp);
        if (!hold) md_start = 1'b0;
        md_src1 = $urandom;
        md_src2 = $urandom;
        md_op = op ^ 3'b101;
        cyc = 1;
        busy_cycles = 0;
        while (!md_valid && cyc < 40) begin
            if (md_busy) busy_cycles++;
            tick();
            cyc++;
        end
        if (md_busy) busy_cycles++;
        md_start = 1'b0;
        want = exp_q.pop_front();
        check({tag, " valid"}, {31'd0, md_valid}, 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy cycles"}, 32'(busy_cycles), 32'(lat));
        check({tag, " result"}, md_result, want);
        tick();
        check({tag, " idle after"}, {30'd0, md_busy, md_valid}, 32'd0);
        check({tag, " result held"}, md_result, want);
    endtask

    initial begin
        int valid_seen;
        tick();
        tick();
        check("reset busy", {31'd0, md_busy}, 32'd0);
        check("reset valid", {31'd0, md_valid}, 32'd0);
        check("reset result", md_result, 32'd0);
        rst = 1'b0;
        tick();

        run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
        run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("MULH -3*5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("MULHU held start", 3'd3, 32'h8000_0000, 32'd4, 32'd2, 33, 1'b1);
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("REM 7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);

        // Flush at iteration 10 with md_start still high.
        md_op = 3'd0;
        md_src1 = 32'd3;
        md_src2 = 32'd5;
        md_start = 1'b1;
        tick();
        for (int i = 1; i < 11; i++) tick();
        check("flush busy before", {31'd0, md_busy}, 32'd1);
        md_flush = 1'b1;
        tick();
        md_flush = 1'b0;
        md_start = 1'b0;
        check("flush idle", {30'd0, md_busy, md_valid}, 32'd0);
        check("flush result kept", md_result, 32'd14);
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_valid || md_busy) valid_seen++;
            tick();
        end
        check("flush no valid later", 32'(valid_seen), 32'd0);

        // Reset at iteration 20.
        md_op = 3'd5;
        md_src1 = 32'hFFFF_FFFF;
        md_src2 = 32'd3;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 1; i < 21; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid busy", {31'd0, md_busy}, 32'd0);
        check("rst mid valid", {31'd0, md_valid}, 32'd0);
        check("rst mid result", md_result, 32'd0);
        tick();
        run_op("DIVU 9/3 after rst", 3'd5, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
